// File: rtl/h264_pkg.sv
// Shared macroblock geometry for the h264 fetch path: plane bases, index widths and
// the bank/index to linear RAM address mapping.
package h264_pkg;

    localparam int MB_WORDS = 96;
    localparam int Y_BASE   = 0;
    localparam int U_BASE   = 64;
    localparam int V_BASE   = 80;
    localparam int MB_AW    = $clog2(MB_WORDS);
    localparam int RAM_AW   = $clog2(2 * MB_WORDS);

    typedef logic [MB_AW-1:0]  mb_idx_t;
    typedef logic [RAM_AW-1:0] ram_addr_t;

    // Bank 1 sits directly above bank 0, so the store is exactly two macroblocks deep.
    function automatic ram_addr_t ram_addr(input logic bank, input mb_idx_t idx);
        ram_addr_t base;
        if (bank) begin
            base = RAM_AW'(MB_WORDS);
        end else begin
            base = {RAM_AW{1'b0}};
        end
        return base + RAM_AW'(idx);
    endfunction

endpackage

// File: rtl/mb_fetch_server_if.sv
// Loader push channel plus core fetch/release channel of the macroblock fetch server.
interface mb_fetch_server_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_word;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] data_word;
    logic              data_valid;
    logic              mb_avail;
    logic              mb_release;
    logic              err_release;

    modport master (
        output in_valid, in_word, fetch_addr, mb_release,
        input  in_ready, data_word, data_valid, mb_avail, err_release
    );

    modport slave (
        input  in_valid, in_word, fetch_addr, mb_release,
        output in_ready, data_word, data_valid, mb_avail, err_release
    );
endinterface

// File: rtl/mb_bank_ram.sv
// Two-macroblock ping-pong store: one write port, one synchronous read port whose
// output register is forced to zero when no valid read is requested.
module mb_bank_ram
    import h264_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  ram_addr_t         wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  ram_addr_t         rd_addr,
    output logic [DATA_W-1:0] rd_data_r
);

    logic [DATA_W-1:0] mem_r [0:2*MB_WORDS-1];

    // Storage write; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register, cleared on reset and on any cycle without a valid read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/mb_fetch_server.sv
// Macroblock fetch server: fills one bank from the loader while serving core reads
// from the other, handing banks over in strict fill order on mb_release.
module mb_fetch_server
    import h264_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mb_fetch_server_if.slave   bus
);

    logic [1:0] full_r;
    logic       wr_bank_r;
    logic       rd_bank_r;
    mb_idx_t    wr_ptr_r;
    logic       in_ready_r;
    logic       mb_avail_r;
    logic       data_valid_r;
    logic       err_release_r;

    logic [1:0] full_next_s;
    logic       wr_bank_next_s;
    logic       rd_bank_next_s;
    mb_idx_t    wr_ptr_next_s;

    logic       accept_s;
    logic       last_word_s;
    logic       rel_ok_s;
    logic       rel_bad_s;
    logic       rd_en_s;
    mb_idx_t    fetch_idx_s;
    logic [DATA_W-1:0] rd_data_s;

    assign accept_s    = bus.in_valid & in_ready_r;
    assign last_word_s = (wr_ptr_r == mb_idx_t'(MB_WORDS - 1));
    assign rel_ok_s    = bus.mb_release & full_r[rd_bank_r];
    assign rel_bad_s   = bus.mb_release & ~full_r[rd_bank_r];
    assign rd_en_s     = full_r[rd_bank_r] & (bus.fetch_addr < ADDR_W'(MB_WORDS));
    assign fetch_idx_s = bus.fetch_addr[MB_AW-1:0];

    // Next bank state; fill completion and release always touch different banks.
    always_comb begin
        full_next_s    = full_r;
        wr_bank_next_s = wr_bank_r;
        rd_bank_next_s = rd_bank_r;
        wr_ptr_next_s  = wr_ptr_r;
        if (accept_s) begin
            if (last_word_s) begin
                full_next_s[wr_bank_r] = 1'b1;
                wr_ptr_next_s          = {MB_AW{1'b0}};
                wr_bank_next_s         = ~wr_bank_r;
            end else begin
                wr_ptr_next_s = wr_ptr_r + mb_idx_t'(1);
            end
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (rel_ok_s) begin
            full_next_s[rd_bank_r] = 1'b0;
            rd_bank_next_s         = ~rd_bank_r;
        end else begin
            rd_bank_next_s = rd_bank_r;
        end
    end

    // Bank bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r        <= 2'b00;
            wr_bank_r     <= 1'b0;
            rd_bank_r     <= 1'b0;
            wr_ptr_r      <= {MB_AW{1'b0}};
            in_ready_r    <= 1'b0;
            mb_avail_r    <= 1'b0;
            data_valid_r  <= 1'b0;
            err_release_r <= 1'b0;
        end else begin
            full_r       <= full_next_s;
            wr_bank_r    <= wr_bank_next_s;
            rd_bank_r    <= rd_bank_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            in_ready_r   <= ~full_next_s[wr_bank_next_s];
            mb_avail_r   <= full_next_s[rd_bank_next_s];
            // Read uses the pre-release bank, so a fetch in the release cycle sees old data.
            data_valid_r <= rd_en_s;
            if (rel_bad_s) begin
                err_release_r <= 1'b1;
            end
        end
    end

    mb_bank_ram #(
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept_s),
        .wr_addr   (ram_addr(wr_bank_r, wr_ptr_r)),
        .wr_data   (bus.in_word),
        .rd_en     (rd_en_s),
        .rd_addr   (ram_addr(rd_bank_r, fetch_idx_s)),
        .rd_data_r (rd_data_s)
    );

    assign bus.in_ready    = in_ready_r;
    assign bus.mb_avail    = mb_avail_r;
    assign bus.data_valid  = data_valid_r;
    assign bus.data_word   = rd_data_s;
    assign bus.err_release = err_release_r;

endmodule

// File: tb/tb_mb_fetch_server.sv
// Directed bench for mb_fetch_server: fetch expectations queued by the stimulus and
// compared by an independent monitor; flag checks made inline.
module tb_mb_fetch_server;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mb_fetch_server_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mb_fetch_server #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] w;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   fid      = 0;
    bit   fetch_req = 1'b0;
    bit   req_d     = 1'b0;
    int   stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One cycle of stimulus, driven on the falling edge.
    task automatic cyc(input bit v, input logic [31:0] w, input bit rel,
                       input bit fr, input logic [31:0] a, input bit ev, input logic [31:0] ew);
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_word    = w;
        bus.mb_release = rel;
        fetch_req      = fr;
        if (fr) begin
            bus.fetch_addr = a;
            exp_q.push_back('{ev, ew, fid});
            fid++;
        end
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a, input bit ev, input logic [31:0] ew);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, a, ev, ew);
    endtask

    task automatic release_mb();
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic push_mb(input logic [31:0] base, input int n, output int st);
        st = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, base + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            if (!bus.in_ready) st++;
        end
    endtask

    // Remember whether a fetch address was sampled on this edge.
    always @(posedge clk) req_d <= fetch_req;

    // Monitor: compare the response one cycle after each sampled fetch.
    always @(negedge clk) begin
        if (req_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL fetch_underflow: got response with no expectation queued");
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("fetch%0d_valid", mon_e.id), 32'(bus.data_valid), 32'(mon_e.v));
                check($sformatf("fetch%0d_word", mon_e.id), bus.data_word, mon_e.w);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_word    = 32'h0;
        bus.mb_release = 1'b0;
        bus.fetch_addr = 32'h0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mb_avail", 32'(bus.mb_avail), 32'd0);
        check("rst_data_valid", 32'(bus.data_valid), 32'd0);
        check("rst_data_word", bus.data_word, 32'h0);
        check("rst_err", 32'(bus.err_release), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: fill bank 0
        push_mb(32'h000, 95, stalls);
        check("t1_avail_before_last", 32'(bus.mb_avail), 32'd0);
        cyc(1'b1, 32'h05F, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        if (!bus.in_ready) stalls++;
        idle();
        check("t1_stalls", 32'(stalls), 32'd0);
        check("t1_mb_avail", 32'(bus.mb_avail), 32'd1);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        fetch(32'h05, 1'b1, 32'h05);
        fetch(32'h5F, 1'b1, 32'h5F);

        // 2: fill bank 1, then bank store is full
        push_mb(32'h100, 96, stalls);
        idle();
        check("t2_stalls", 32'(stalls), 32'd0);
        check("t2_in_ready", 32'(bus.in_ready), 32'd0);
        check("t2_mb_avail", 32'(bus.mb_avail), 32'd1);
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        fetch(32'h20, 1'b1, 32'h020);
        fetch(32'h40, 1'b1, 32'h040);

        // 3: release with a fetch in the same cycle, then read bank 1
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h020);
        fetch(32'h20, 1'b1, 32'h120);
        check("t3_in_ready", 32'(bus.in_ready), 32'd1);
        check("t3_mb_avail", 32'(bus.mb_avail), 32'd1);

        // 4: out-of-range addresses with a full bank
        fetch(32'd96, 1'b0, 32'h0);
        fetch(32'hFFFF_FFFF, 1'b0, 32'h0);
        fetch(32'h5F, 1'b1, 32'h15F);
        idle();
        check("t4_err", 32'(bus.err_release), 32'd0);

        // 5: drain, then release with nothing available
        release_mb();
        idle();
        check("t5_mb_avail", 32'(bus.mb_avail), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        fetch(32'h05, 1'b0, 32'h0);
        release_mb();
        idle();
        check("t5_err_set", 32'(bus.err_release), 32'd1);
        repeat (3) idle();
        check("t5_err_sticky", 32'(bus.err_release), 32'd1);
        check("t5_mb_avail_still0", 32'(bus.mb_avail), 32'd0);
        push_mb(32'h200, 96, stalls);
        idle();
        check("t5_stalls", 32'(stalls), 32'd0);
        check("t5_mb_avail_refill", 32'(bus.mb_avail), 32'd1);
        fetch(32'h10, 1'b1, 32'h210);
        fetch(32'h00, 1'b1, 32'h200);

        // 6: last word into bank 1 together with release of bank 0
        push_mb(32'h300, 95, stalls);
        cyc(1'b1, 32'h35F, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
        check("t6_stalls", 32'(stalls), 32'd0);
        check("t6_mb_avail", 32'(bus.mb_avail), 32'd1);
        check("t6_in_ready", 32'(bus.in_ready), 32'd1);
        fetch(32'h5F, 1'b1, 32'h35F);
        fetch(32'h00, 1'b1, 32'h300);
        idle();

        // 6: reset in the middle of a fill
        push_mb(32'h400, 40, stalls);
        idle();
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t6_rst_mb_avail", 32'(bus.mb_avail), 32'd0);
        check("t6_rst_err", 32'(bus.err_release), 32'd0);
        check("t6_rst_data_valid", 32'(bus.data_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        push_mb(32'h500, 96, stalls);
        idle();
        check("t6_post_rst_stalls", 32'(stalls), 32'd0);
        check("t6_post_rst_avail", 32'(bus.mb_avail), 32'd1);
        fetch(32'h00, 1'b1, 32'h500);
        fetch(32'd39, 1'b1, 32'h527);
        fetch(32'h50, 1'b1, 32'h550);
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
